// File: rtl/dht_poll_sequencer.sv
// Round-robin DHT22 poller: shares one reader core across NUM_CH sensors and tracks per-channel health.
// Optional build macro DISP_AUTOROTATE_EN adds a 3000 ms display auto-advance.
module dht_poll_sequencer #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned PERIOD_MS  = 1000,
    parameter int unsigned GAP_MS     = 10,
    parameter int unsigned TIMEOUT_MS = 50,
    parameter int unsigned FAIL_LIMIT = 3,
    parameter int unsigned ERRW       = 4,
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick_ms,
    output logic                   rd_start,
    output logic [CW-1:0]          rd_chan,
    input  logic                   rd_done,
    input  logic [39:0]            rd_data,
    input  logic                   disp_next,
    output logic [15:0]            disp_value,
    output logic [CW-1:0]          disp_chan,
    output logic                   disp_is_hum,
    input  logic [CW-1:0]          host_addr,
    output logic [31:0]            host_data,
    output logic [NUM_CH-1:0]      ch_valid,
    output logic [NUM_CH*ERRW-1:0] err_cnt,
    output logic                   busy
);

    localparam int unsigned PW   = (PERIOD_MS > 1) ? $clog2(PERIOD_MS) : 1;
    localparam int unsigned TW   = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
    localparam int unsigned GW   = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
    localparam int unsigned FW   = $clog2(FAIL_LIMIT + 1);
    localparam int unsigned NCAP = 1 << CW;
    localparam logic [NCAP-1:0] CH_MASK = NCAP'((1 << NUM_CH) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_FAIL,
        S_GAP
    } state_t;

    state_t            state;
    logic [PW-1:0]     period_cnt;
    logic              pending;
    logic [TW-1:0]     tmo_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              chk_ok;
    logic [15:0]       hum_q   [NUM_CH];
    logic [15:0]       temp_q  [NUM_CH];
    logic [ERRW-1:0]   err_q   [NUM_CH];
    logic [FW-1:0]     fcnt_q  [NUM_CH];
    logic [NUM_CH-1:0] valid_q;

    logic period_hit_c;
    logic sum_ok_c;
    logic disp_adv_c;

    assign period_hit_c = tick_ms && (period_cnt == PW'(PERIOD_MS - 1));
    assign sum_ok_c     = (8'(rd_data[39:32] + rd_data[31:24] + rd_data[23:16] + rd_data[15:8])
                           == rd_data[7:0]);

    // Polling sequencer; rd_start is high exactly while in S_START.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            period_cnt <= '0;
            pending    <= 1'b0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            chk_ok     <= 1'b0;
            rd_start   <= 1'b0;
            rd_chan    <= '0;
            busy       <= 1'b0;
            valid_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hum_q[i]  <= '0;
                temp_q[i] <= '0;
                err_q[i]  <= '0;
                fcnt_q[i] <= '0;
            end
        end else begin
            rd_start <= 1'b0;
            if (tick_ms) begin
                period_cnt <= period_hit_c ? '0 : period_cnt + PW'(1);
            end
            // A period expiring mid-round is held and served on return to idle.
            if (period_hit_c && state != S_IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (pending || period_hit_c) begin
                        pending  <= 1'b0;
                        rd_chan  <= '0;
                        busy     <= 1'b1;
                        rd_start <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // Good frames are latched on the rd_done edge so hosts see them a clock later.
                    if (rd_done) begin
                        chk_ok <= sum_ok_c;
                        if (sum_ok_c) begin
                            hum_q[rd_chan]   <= rd_data[39:24];
                            temp_q[rd_chan]  <= rd_data[23:8];
                            valid_q[rd_chan] <= 1'b1;
                            fcnt_q[rd_chan]  <= '0;
                        end
                        state <= S_CHECK;
                    end else if (tick_ms) begin
                        if (tmo_cnt == TW'(TIMEOUT_MS - 1)) begin
                            state <= S_FAIL;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    gap_cnt <= '0;
                    state   <= chk_ok ? S_GAP : S_FAIL;
                end
                S_FAIL: begin
                    if (err_q[rd_chan] != '1) begin
                        err_q[rd_chan] <= err_q[rd_chan] + ERRW'(1);
                    end
                    if (fcnt_q[rd_chan] != FW'(FAIL_LIMIT)) begin
                        fcnt_q[rd_chan] <= fcnt_q[rd_chan] + FW'(1);
                        if (fcnt_q[rd_chan] == FW'(FAIL_LIMIT - 1)) begin
                            valid_q[rd_chan] <= 1'b0;
                        end
                    end
                    gap_cnt <= '0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (tick_ms) begin
                        if (gap_cnt == GW'(GAP_MS - 1)) begin
                            gap_cnt <= '0;
                            if (rd_chan == CW'(NUM_CH - 1)) begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end else begin
                                rd_chan  <= rd_chan + CW'(1);
                                rd_start <= 1'b1;
                                state    <= S_START;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DISP_AUTOROTATE_EN
    logic [11:0] rot_cnt;
    logic        rot_hit_c;

    assign rot_hit_c  = tick_ms && (rot_cnt == 12'd2999);
    assign disp_adv_c = disp_next || rot_hit_c;

    // Auto-rotate timer; a manual press restarts the interval.
    always_ff @(posedge clock) begin
        if (reset) begin
            rot_cnt <= '0;
        end else if (disp_adv_c) begin
            rot_cnt <= '0;
        end else if (tick_ms) begin
            rot_cnt <= rot_cnt + 12'd1;
        end
    end
`else
    assign disp_adv_c = disp_next;
`endif

    // Show hum then temp of a channel before moving on to the next channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_chan   <= '0;
            disp_is_hum <= 1'b1;
        end else if (disp_adv_c) begin
            disp_is_hum <= ~disp_is_hum;
            if (!disp_is_hum) begin
                disp_chan <= (disp_chan == CW'(NUM_CH - 1)) ? '0 : disp_chan + CW'(1);
            end
        end
    end

    always_comb begin
        disp_value = 16'h0000;
        if (valid_q[disp_chan]) begin
            disp_value = disp_is_hum ? hum_q[disp_chan] : temp_q[disp_chan];
        end
    end

    always_comb begin
        host_data = 32'h0;
        if (CH_MASK[host_addr]) begin
            host_data = {hum_q[host_addr], temp_q[host_addr]};
        end
    end

    always_comb begin
        err_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            err_cnt[i*ERRW +: ERRW] = err_q[i];
        end
    end

    assign ch_valid = valid_q;

endmodule

// File: tb/tb_dht_poll_sequencer.sv
// Directed bench for dht_poll_sequencer with two channels and shortened ms timing.
module tb_dht_poll_sequencer;

    localparam int unsigned NUM_CH     = 2;
    localparam int unsigned PERIOD_MS  = 20;
    localparam int unsigned GAP_MS     = 2;
    localparam int unsigned TIMEOUT_MS = 5;
    localparam int unsigned FAIL_LIMIT = 3;
    localparam int unsigned ERRW       = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick_ms;
    logic        rd_start;
    logic [0:0]  rd_chan;
    logic        rd_done;
    logic [39:0] rd_data;
    logic        disp_next;
    logic [15:0] disp_value;
    logic [0:0]  disp_chan;
    logic        disp_is_hum;
    logic [0:0]  host_addr;
    logic [31:0] host_data;
    logic [1:0]  ch_valid;
    logic [7:0]  err_cnt;
    logic        busy;

    dht_poll_sequencer #(
        .NUM_CH(NUM_CH), .PERIOD_MS(PERIOD_MS), .GAP_MS(GAP_MS),
        .TIMEOUT_MS(TIMEOUT_MS), .FAIL_LIMIT(FAIL_LIMIT), .ERRW(ERRW)
    ) dut (
        .clock(clock), .reset(reset), .tick_ms(tick_ms),
        .rd_start(rd_start), .rd_chan(rd_chan), .rd_done(rd_done), .rd_data(rd_data),
        .disp_next(disp_next), .disp_value(disp_value), .disp_chan(disp_chan),
        .disp_is_hum(disp_is_hum), .host_addr(host_addr), .host_data(host_data),
        .ch_valid(ch_valid), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          chan;
        int          kind;       // 0 good frame, 1 bad checksum, 2 no answer
        logic [39:0] data;
        logic [1:0]  exp_valid;
        logic [3:0]  exp_err1;
        logic [31:0] exp_host;
        int          exp_ticks;  // ticks from previous read to rd_start, -1 = not checked
    } rd_vec_t;

    typedef struct {
        logic        exp_chan;
        logic        exp_hum;
        logic [15:0] exp_value;
    } disp_vec_t;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] cur_err1 = 4'd0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_cyc();
        tick_ms = 1'b1;
        cyc();
        tick_ms = 1'b0;
    endtask

    // Issue ms ticks until rd_start shows up; n returns the ticks used.
    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (n < budget && !rd_start) begin
            tick_cyc();
            n++;
            if (!rd_start) cyc();
        end
        checks++;
        if (!rd_start) begin
            failures++;
            $display("FAIL start_wait: no rd_start within %0d ticks", budget);
        end
    endtask

    task automatic serve(input int kind, input logic [39:0] data, input logic [31:0] exp_host);
        cyc();
        chk("rd_start_one_cycle", rd_start, 1'b0);
        if (kind < 2) begin
            rd_done = 1'b1;
            rd_data = data;
            cyc();
            rd_done = 1'b0;
            rd_data = '0;
            if (kind == 0) chk("host_latency", host_data, exp_host);
            cyc();
            cyc();
        end else begin
            repeat (TIMEOUT_MS - 1) begin
                tick_cyc();
                cyc();
            end
            chk("no_early_timeout", err_cnt[7:4], cur_err1);
            tick_cyc();
            cyc();
            cyc();
        end
    endtask

    task automatic run_entry(input rd_vec_t v);
        int n;
        host_addr = 1'(v.chan);
        wait_start(30, n);
        chk("rd_chan", rd_chan, v.chan);
        chk("busy_in_round", busy, 1'b1);
        if (v.exp_ticks >= 0) chk("start_ticks", n, v.exp_ticks);
        serve(v.kind, v.data, v.exp_host);
        chk("ch_valid", ch_valid, v.exp_valid);
        chk("err_cnt", err_cnt, {v.exp_err1, 4'h0});
        chk("host_data", host_data, v.exp_host);
        cur_err1 = v.exp_err1;
    endtask

    task automatic press();
        disp_next = 1'b1;
        cyc();
        disp_next = 1'b0;
        cyc();
    endtask

    localparam logic [39:0] FA  = 40'h0190_00F5_86;
    localparam logic [39:0] FB  = 40'h0222_FF9C_BF;
    localparam logic [39:0] FC  = 40'h0200_0100_03;
    localparam logic [39:0] FB2 = 40'h0250_0100_53;
    localparam logic [39:0] FX  = 40'h0300_0200_00;

    initial begin
        rd_vec_t   tbl [12];
        disp_vec_t dtbl [4];
        rd_vec_t   v;
        int        n;
        logic [3:0] e;

        tbl[0]  = '{0, 0, FA,  2'b01, 4'd0, 32'h0190_00F5, 20};
        tbl[1]  = '{1, 0, FB,  2'b11, 4'd0, 32'h0222_FF9C, 2};
        tbl[2]  = '{0, 0, FC,  2'b11, 4'd0, 32'h0200_0100, -1};
        tbl[3]  = '{1, 1, FX,  2'b11, 4'd1, 32'h0222_FF9C, 2};
        tbl[4]  = '{0, 0, FA,  2'b11, 4'd1, 32'h0190_00F5, -1};
        tbl[5]  = '{1, 0, FB2, 2'b11, 4'd1, 32'h0250_0100, 2};
        tbl[6]  = '{0, 0, FA,  2'b11, 4'd1, 32'h0190_00F5, -1};
        tbl[7]  = '{1, 2, '0,  2'b11, 4'd2, 32'h0250_0100, 2};
        tbl[8]  = '{0, 0, FA,  2'b11, 4'd2, 32'h0190_00F5, -1};
        tbl[9]  = '{1, 2, '0,  2'b11, 4'd3, 32'h0250_0100, 2};
        tbl[10] = '{0, 0, FA,  2'b11, 4'd3, 32'h0190_00F5, -1};
        tbl[11] = '{1, 2, '0,  2'b01, 4'd4, 32'h0250_0100, 2};

        dtbl[0] = '{1'b0, 1'b0, 16'h00F5};
        dtbl[1] = '{1'b1, 1'b1, 16'h0222};
        dtbl[2] = '{1'b1, 1'b0, 16'hFF9C};
        dtbl[3] = '{1'b0, 1'b1, 16'h0190};

        reset     = 1'b1;
        tick_ms   = 1'b0;
        rd_done   = 1'b0;
        rd_data   = '0;
        disp_next = 1'b0;
        host_addr = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        chk("rst_rd_start", rd_start, 1'b0);
        chk("rst_rd_chan", rd_chan, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ch_valid", ch_valid, 2'b00);
        chk("rst_err_cnt", err_cnt, 8'h00);
        chk("rst_disp_chan", disp_chan, 1'b0);
        chk("rst_disp_is_hum", disp_is_hum, 1'b1);
        chk("rst_disp_value", disp_value, 16'h0000);
        chk("rst_host_data", host_data, 32'h0);

        for (int i = 0; i < 2; i++) run_entry(tbl[i]);

        chk("disp_init_value", disp_value, 16'h0190);
        for (int i = 0; i < 4; i++) begin
            press();
            chk("disp_chan", disp_chan, dtbl[i].exp_chan);
            chk("disp_is_hum", disp_is_hum, dtbl[i].exp_hum);
            chk("disp_value", disp_value, dtbl[i].exp_value);
        end

        for (int i = 2; i < 12; i++) run_entry(tbl[i]);

        // Channel 1 is now invalid: its display slot reads zero.
        press();
        press();
        chk("disp_invalid_chan", disp_chan, 1'b1);
        chk("disp_invalid_value", disp_value, 16'h0000);

        // Twelve more silent rounds drive channel 1's counter into saturation.
        e = 4'd4;
        for (int r = 0; r < 12; r++) begin
            v = '{0, 0, FA, 2'b01, e, 32'h0190_00F5, -1};
            run_entry(v);
            e = (e == 4'd15) ? 4'd15 : e + 4'd1;
            v = '{1, 2, '0, 2'b01, e, 32'h0250_0100, 2};
            run_entry(v);
        end
        chk("err_saturated", err_cnt[7:4], 4'd15);

        // Reset in the middle of a read, then a late rd_done.
        host_addr = 1'b0;
        wait_start(30, n);
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        reset   = 1'b0;
        rd_done = 1'b1;
        rd_data = 40'h0300_0400_07;
        cyc();
        rd_done = 1'b0;
        rd_data = '0;
        cyc();
        chk("mid_rst_valid", ch_valid, 2'b00);
        chk("mid_rst_err", err_cnt, 8'h00);
        chk("mid_rst_host", host_data, 32'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rd_start", rd_start, 1'b0);
        wait_start(30, n);
        chk("mid_rst_start_ticks", n, 20);
        chk("mid_rst_rd_chan", rd_chan, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
